// File: rtl/rbm_read_master.sv
// rbm_read_master: Avalon-MM burstless read master with an internal
// show-ahead FIFO. A base/length/go command streams whole words from memory
// into the FIFO, which the user side pops. Outstanding reads are throttled so
// that FIFO occupancy plus reads in flight never exceeds FIFO_DEPTH.
// Optional build macro: RBM_READ_PERF_EN adds perf_busy_cycles and
// perf_stall_cycles counters.

// Occupancy invariants of the read master; kept apart from the datapath.
module rbm_read_master_chk #(
  parameter int FIFO_DEPTH      = 32,
  parameter int FIFO_DEPTH_LOG2 = 5
) (
  input logic                     clk,
  input logic                     reset,
  input logic [FIFO_DEPTH_LOG2:0] fifo_used,
  input logic [FIFO_DEPTH_LOG2:0] outstanding
);

  // FIFO never overfills and in-flight reads always have a slot reserved.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (fifo_used <= (FIFO_DEPTH_LOG2 + 1)'(FIFO_DEPTH));
      assert (({1'b0, fifo_used} + {1'b0, outstanding}) <= (FIFO_DEPTH_LOG2 + 2)'(FIFO_DEPTH));
    end
  end

endmodule

module rbm_read_master #(
  parameter int DATAWIDTH       = 32,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int FIFO_DEPTH      = 32,
  parameter int FIFO_DEPTH_LOG2 = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       control_fixed_location,
  input  logic [ADDRESS_WIDTH-1:0]   control_read_base,
  input  logic [ADDRESS_WIDTH-1:0]   control_read_length,
  input  logic                       control_go,
  output logic                       control_done,
  output logic                       control_early_done,
  input  logic                       user_read_buffer,
  output logic [DATAWIDTH-1:0]       user_buffer_data,
  output logic                       user_data_available,
  output logic [ADDRESS_WIDTH-1:0]   master_address,
  output logic                       master_read,
  output logic [DATAWIDTH/8-1:0]     master_byteenable,
  input  logic [DATAWIDTH-1:0]       master_readdata,
  input  logic                       master_readdatavalid,
  input  logic                       master_waitrequest
`ifdef RBM_READ_PERF_EN
  ,
  output logic [31:0]                perf_busy_cycles,
  output logic [31:0]                perf_stall_cycles
`endif
);

  localparam int CW  = FIFO_DEPTH_LOG2 + 1;
  localparam int BPW = DATAWIDTH / 8;
  localparam logic [ADDRESS_WIDTH-1:0]   BPW_A      = ADDRESS_WIDTH'(BPW);
  localparam logic [ADDRESS_WIDTH-1:0]   ALIGN_MASK = ~(BPW_A - ADDRESS_WIDTH'(1));
  localparam logic [ADDRESS_WIDTH-1:0]   A_ZERO     = ADDRESS_WIDTH'(0);
  localparam logic [CW-1:0]              CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]              CNT_ZERO   = CW'(0);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = FIFO_DEPTH_LOG2'(1);
  localparam logic [CW:0]                DEPTH_W    = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0]   remaining_q, remaining_d;
  logic                       fixed_q, fixed_d;
  logic                       done_q, done_d;
  logic                       early_done_q, early_done_d;
  logic                       read_q, read_d;
  logic                       go_prev_q;
  logic [CW-1:0]              outstanding_q, outstanding_d;
  logic [CW-1:0]              used_q, used_d;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DATAWIDTH-1:0]       head_q, head_d;
  logic                       avail_q, avail_d;
  logic [DATAWIDTH-1:0]       mem_q [FIFO_DEPTH];

  logic go_start_s;
  logic accept_s;
  logic push_s;
  logic pop_s;

  // Rising edge of go starts a transfer; a level-held go starts only one.
  assign go_start_s = control_go & ~go_prev_q;
  assign accept_s   = read_q & ~master_waitrequest;
  // Returned data is only meaningful while a read is actually in flight.
  assign push_s     = master_readdatavalid & (outstanding_q != CNT_ZERO);
  assign pop_s      = user_read_buffer & avail_q;

  // Next-state logic for the transfer FSM, in-flight counter and FIFO.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    fixed_d       = fixed_q;
    done_d        = done_q;
    early_done_d  = early_done_q;
    outstanding_d = outstanding_q;
    used_d        = used_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    head_d        = head_q;

    case (state_q)
      S_IDLE: begin
        if (go_start_s) begin
          addr_d       = control_read_base & ALIGN_MASK;
          remaining_d  = control_read_length & ALIGN_MASK;
          fixed_d      = control_fixed_location;
          done_d       = 1'b0;
          early_done_d = 1'b0;
          state_d      = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (remaining_q == A_ZERO) begin
          early_done_d = 1'b1;
          state_d      = S_DRAIN;
        end else if (accept_s) begin
          addr_d      = fixed_q ? addr_q : (addr_q + BPW_A);
          remaining_d = remaining_q - BPW_A;
        end else begin
          state_d = S_READ;
        end
      end
      S_DRAIN: begin
        if ((outstanding_q == CNT_ZERO) && (used_q == CNT_ZERO)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case ({accept_s, push_s})
      2'b10:   outstanding_d = outstanding_q + CNT_ONE;
      2'b01:   outstanding_d = outstanding_q - CNT_ONE;
      default: outstanding_d = outstanding_q;
    endcase

    case ({push_s, pop_s})
      2'b10:   used_d = used_q + CNT_ONE;
      2'b01:   used_d = used_q - CNT_ONE;
      default: used_d = used_q;
    endcase

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // The head register shows the pushed word directly when it lands in an
    // otherwise-empty FIFO; otherwise it shows the stored entry at rd_ptr_d.
    if (push_s && (used_q == CW'(pop_s))) begin
      head_d = master_readdata;
    end else if (used_d != CNT_ZERO) begin
      head_d = mem_q[rd_ptr_d];
    end else begin
      head_d = head_q;
    end

    avail_d = (used_d != CNT_ZERO);

    // Registered read strobe: next-cycle value of the read/throttle equation.
    read_d = (state_d == S_READ) && (remaining_d != A_ZERO) &&
             (({1'b0, used_d} + {1'b0, outstanding_d}) < DEPTH_W);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      addr_q        <= A_ZERO;
      remaining_q   <= A_ZERO;
      fixed_q       <= 1'b0;
      done_q        <= 1'b0;
      early_done_q  <= 1'b0;
      read_q        <= 1'b0;
      go_prev_q     <= 1'b0;
      outstanding_q <= CNT_ZERO;
      used_q        <= CNT_ZERO;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      head_q        <= '0;
      avail_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      fixed_q       <= fixed_d;
      done_q        <= done_d;
      early_done_q  <= early_done_d;
      read_q        <= read_d;
      go_prev_q     <= control_go;
      outstanding_q <= outstanding_d;
      used_q        <= used_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      head_q        <= head_d;
      avail_q       <= avail_d;
    end
  end

  // FIFO storage; flushing is done by the pointer/count reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= master_readdata;
    end
  end

  assign control_done        = done_q;
  assign control_early_done  = early_done_q;
  assign user_buffer_data    = head_q;
  assign user_data_available = avail_q;
  assign master_address      = addr_q;
  assign master_read         = read_q;
  assign master_byteenable   = {(DATAWIDTH/8){1'b1}};

`ifdef RBM_READ_PERF_EN
  logic [31:0] busy_q;
  logic [31:0] stall_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 32'd1;
    end
  endfunction

  // Saturating busy/stall counters, cleared when a transfer starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= 32'd0;
      stall_q <= 32'd0;
    end else if (go_start_s && (state_q == S_IDLE)) begin
      busy_q  <= 32'd0;
      stall_q <= 32'd0;
    end else begin
      busy_q  <= (state_q != S_IDLE) ? sat_inc(busy_q) : busy_q;
      stall_q <= (read_q && master_waitrequest) ? sat_inc(stall_q) : stall_q;
    end
  end

  assign perf_busy_cycles  = busy_q;
  assign perf_stall_cycles = stall_q;
`endif

  rbm_read_master_chk #(
    .FIFO_DEPTH      (FIFO_DEPTH),
    .FIFO_DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_chk (
    .clk         (clk),
    .reset       (reset),
    .fifo_used   (used_q),
    .outstanding (outstanding_q)
  );

endmodule

// File: tb/tb_rbm_read_master.sv
// Directed bench for rbm_read_master (FIFO_DEPTH=4). Inputs change on the
// falling edge, outputs are sampled on the falling edge. A small memory
// model answers every accepted read two cycles later with data 1,2,3,...
module tb_rbm_read_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        control_fixed_location;
  logic [31:0] control_read_base;
  logic [31:0] control_read_length;
  logic        control_go;
  logic        control_done;
  logic        control_early_done;
  logic        user_read_buffer;
  logic [31:0] user_buffer_data;
  logic        user_data_available;
  logic [31:0] master_address;
  logic        master_read;
  logic [3:0]  master_byteenable;
  logic [31:0] master_readdata = 32'hFFFF_FFFF;
  logic        master_readdatavalid = 1'b0;
  logic        master_waitrequest;

  int n_cmp = 0;
  int n_err = 0;
  int data_ctr = 1;
  logic pipe0 = 1'b0;
  logic pipe1 = 1'b0;
  logic [31:0] addr_log [$];

  always #5 clk = ~clk;

  rbm_read_master #(
    .DATAWIDTH(32), .ADDRESS_WIDTH(32), .FIFO_DEPTH(4), .FIFO_DEPTH_LOG2(2)
  ) dut (
    .clk(clk), .reset(reset),
    .control_fixed_location(control_fixed_location),
    .control_read_base(control_read_base),
    .control_read_length(control_read_length),
    .control_go(control_go),
    .control_done(control_done),
    .control_early_done(control_early_done),
    .user_read_buffer(user_read_buffer),
    .user_buffer_data(user_buffer_data),
    .user_data_available(user_data_available),
    .master_address(master_address),
    .master_read(master_read),
    .master_byteenable(master_byteenable),
    .master_readdata(master_readdata),
    .master_readdatavalid(master_readdatavalid),
    .master_waitrequest(master_waitrequest)
  );

  // Memory model: logs each handshake and returns data two edges later.
  always @(negedge clk) begin
    #1;
    master_readdatavalid = pipe1;
    if (pipe1) begin
      master_readdata = 32'(data_ctr);
      data_ctr++;
    end else begin
      master_readdata = 32'hFFFF_FFFF;
    end
    pipe1 = pipe0;
    pipe0 = (!reset && master_read && !master_waitrequest);
    if (pipe0) addr_log.push_back(master_address);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_flag(input string tag, input bit sel_done);
    int k = 0;
    while (!(sel_done ? control_done : control_early_done) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(sel_done ? control_done : control_early_done), 32'd1);
  endtask

  task automatic pop_expect(input logic [31:0] exp);
    int k = 0;
    while (!user_data_available && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("pop_avail", 32'(user_data_available), 32'd1);
    check("pop_data", user_buffer_data, exp);
    user_read_buffer = 1'b1;
    @(negedge clk);
    user_read_buffer = 1'b0;
  endtask

  initial begin
    reset = 1'b1; control_go = 1'b0; control_fixed_location = 1'b0;
    control_read_base = 32'd0; control_read_length = 32'd0;
    user_read_buffer = 1'b0; master_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_read", 32'(master_read), 32'd0);
    check("rst_addr", master_address, 32'd0);
    check("rst_done", 32'(control_done), 32'd0);
    check("rst_early", 32'(control_early_done), 32'd0);
    check("rst_avail", 32'(user_data_available), 32'd0);
    check("rst_data", user_buffer_data, 32'd0);
    check("byteenable", 32'(master_byteenable), 32'h0000_000F);
    reset = 1'b0;
    @(negedge clk);

    // Basic 4-word transfer from 0x100.
    control_read_base = 32'h100; control_read_length = 32'd16; control_go = 1'b1;
    @(negedge clk);
    check("t1_first_read", 32'(master_read), 32'd1);
    check("t1_first_addr", master_address, 32'h100);
    control_go = 1'b0;
    wait_flag("t1_early", 1'b0);
    check("t1_done_low", 32'(control_done), 32'd0);
    for (int i = 1; i <= 4; i++) pop_expect(32'(i));
    wait_flag("t1_done", 1'b1);
    check("t1_nreads", 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("t1_addr", addr_log[i], 32'h100 + 32'(4 * i));

    // Zero length: no reads, early_done then done on consecutive edges.
    control_read_base = 32'h200; control_read_length = 32'd0; control_go = 1'b1;
    @(negedge clk);
    check("t2_read0", 32'(master_read), 32'd0);
    check("t2_early0", 32'(control_early_done), 32'd0);
    check("t2_done0", 32'(control_done), 32'd0);
    control_go = 1'b0;
    @(negedge clk);
    check("t2_early1", 32'(control_early_done), 32'd1);
    check("t2_done1", 32'(control_done), 32'd0);
    @(negedge clk);
    check("t2_done2", 32'(control_done), 32'd1);
    check("t2_read2", 32'(master_read), 32'd0);
    check("t2_nreads", 32'(addr_log.size()), 32'd4);

    // Fixed location, length 14 truncates to 3 words, all at 0x40.
    control_fixed_location = 1'b1; control_read_base = 32'h40;
    control_read_length = 32'd14; control_go = 1'b1;
    @(negedge clk);
    control_go = 1'b0;
    for (int i = 5; i <= 7; i++) pop_expect(32'(i));
    wait_flag("t3_done", 1'b1);
    check("t3_nreads", 32'(addr_log.size()), 32'd7);
    for (int i = 4; i < 7; i++) check("t3_addr", addr_log[i], 32'h40);
    control_fixed_location = 1'b0;

    // Throttle: 16 words into a 4-deep FIFO with no pops.
    control_read_base = 32'h1000; control_read_length = 32'd64; control_go = 1'b1;
    @(negedge clk);
    control_go = 1'b0;
    repeat (15) @(negedge clk);
    check("t4_nreads_full", 32'(addr_log.size()), 32'd11);
    check("t4_read_stop", 32'(master_read), 32'd0);
    check("t4_avail", 32'(user_data_available), 32'd1);
    pop_expect(32'd8);
    repeat (15) @(negedge clk);
    check("t4_nreads_one", 32'(addr_log.size()), 32'd12);
    check("t4_read_stop2", 32'(master_read), 32'd0);
    for (int i = 9; i <= 23; i++) pop_expect(32'(i));
    wait_flag("t4_done", 1'b1);
    check("t4_nreads", 32'(addr_log.size()), 32'd23);
    check("t4_addr5", addr_log[11], 32'h1010);
    check("t4_addr16", addr_log[22], 32'h103C);

    // Waitrequest stalls the first read for 5 edges; go stays high.
    control_read_base = 32'h200; control_read_length = 32'd8;
    master_waitrequest = 1'b1; control_go = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_hold_read", 32'(master_read), 32'd1);
      check("t5_hold_addr", master_address, 32'h200);
    end
    check("t5_no_accept", 32'(addr_log.size()), 32'd23);
    master_waitrequest = 1'b0;
    pop_expect(32'd24);
    pop_expect(32'd25);
    wait_flag("t5_done", 1'b1);
    check("t5_addr0", addr_log[23], 32'h200);
    check("t5_addr1", addr_log[24], 32'h204);
    repeat (5) @(negedge clk);
    check("t5_go_level_read", 32'(master_read), 32'd0);
    check("t5_go_level_done", 32'(control_done), 32'd1);
    check("t5_go_level_n", 32'(addr_log.size()), 32'd25);
    control_go = 1'b0;
    @(negedge clk);

    // Reset with two reads in flight; their data must be dropped.
    control_read_base = 32'h300; control_read_length = 32'd16; control_go = 1'b1;
    @(negedge clk);
    control_go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t6_pre_read", 32'(master_read), 32'd1);
    check("t6_pre_addr", master_address, 32'h308);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_read", 32'(master_read), 32'd0);
    check("t6_rst_addr", master_address, 32'd0);
    check("t6_rst_early", 32'(control_early_done), 32'd0);
    check("t6_rst_avail", 32'(user_data_available), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_late_avail", 32'(user_data_available), 32'd0);
    check("t6_late_data", user_buffer_data, 32'd0);
    check("t6_late_read", 32'(master_read), 32'd0);
    check("t6_late_done", 32'(control_done), 32'd0);
    check("t6_nreads", 32'(addr_log.size()), 32'd27);

    // Recovery: single word after the reset.
    control_read_base = 32'h500; control_read_length = 32'd4; control_go = 1'b1;
    @(negedge clk);
    control_go = 1'b0;
    pop_expect(32'd28);
    wait_flag("t7_done", 1'b1);
    check("t7_nreads", 32'(addr_log.size()), 32'd28);
    check("t7_addr", addr_log[27], 32'h500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
